pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage LoongArch pipeline (IF/ID/EX/MEM/WB) downstream of the instruction decoder.
//  Owns the per-stage valid bits, allowin/ready_go handshakes, dest-register scoreboard, RAW interlock,
//  forwarding selects and taken-branch squash of the IF slot. Does not move datapath payloads; it only
//  produces enables and selects.
// PARAMETERS
//  REG_AW   5   register-index width (32 GPRs; r0 never creates a hazard)
// PORTS
//  clk           in   1       pipeline clock
//  resetn        in   1       asynchronous, active-low reset
//  fs_to_ds_valid in  1       IF presents a valid instruction this cycle
//  ds_rj         in   REG_AW  ID source 1 (decoder rj)
//  ds_rkd        in   REG_AW  ID source 2 (rk, or rd for beq/bne/st.w)
//  ds_use_rj     in   1       source 1 actually read
//  ds_use_rkd    in   1       source 2 actually read
//  ds_dest       in   REG_AW  ID destination (rd, or 1 for bl)
//  ds_gr_we      in   1       ID instruction writes GPR
//  ds_is_load    in   1       ID instruction is ld.w
//  ds_br_taken   in   1       ID resolved a taken branch/jump
//  ms_mem_ready  in   1       MEM data response available (ms_ready_go)
//  ds_allowin    out  1       IF may hand over an instruction
//  ds_valid/es_valid/ms_valid/ws_valid  out 1 each   stage valid bits
//  ds_to_es_fire out  1       ID->EX transfer this cycle (latch enable for EX payload)
//  es_to_ms_fire out  1       EX->MEM latch enable
//  ms_to_ws_fire out  1       MEM->WB latch enable
//  fs_flush      out  1       squash the IF instruction/redirect PC (combinational)
//  fwd_rj_sel    out  2       0 regfile, 1 EX, 2 MEM, 3 WB
//  fwd_rkd_sel   out  2       same encoding for source 2
//  ds_stall      out  1       RAW interlock holding ID
// BEHAVIOUR
//  Reset: all valid regs 0, scoreboard dest/we/is_load 0; outputs ds_allowin=1, fires 0, fs_flush 0,
//   fwd sels 0, ds_stall 0. Reset mid-flight discards every in-flight instruction.
//  ready_go: ds = ~ds_stall; es = 1; ms = ms_mem_ready; ws = 1.
//  allowin: X_allowin = ~X_valid | (X_ready_go & next_allowin); ws_allowin = 1.
//  fire: X_to_Y_fire = X_valid & X_ready_go & Y_allowin. On fire Y_valid<=1 and Y's dest/we/is_load latch
//   from X; if Y_allowin & ~fire, Y_valid<=0. Stage holds (unchanged) when ~Y_allowin.
//  ds_valid: on ds_allowin, ds_valid <= fs_to_ds_valid & ~fs_flush.
//  fs_flush = ds_br_taken & ds_to_es_fire: 1-cycle squash; stalled branch never flushes until it fires.
//  Hazard match per source s in {rj,rkd}: use_s & s!=0 & X_valid & X_we & X_dest==s, X in {es,ms,ws}.
//  Priority youngest first: EX > MEM > WB for select and stall.
//  Simultaneous: ID reg written by WB the same cycle -> select 3 (regfile write not yet visible).
//  Back-to-back identical dests: only youngest match matters.
//  ms_mem_ready=0 stalls MEM, back-pressures EX and ID; fwd selects stay stable while held.
// CONFIGURATION
//  `PIPE_FWD_BYPASS_EN defined: fwd sels as above; ds_stall = (EX match & es_is_load)
//   | (MEM match & ms_is_load & ~ms_mem_ready). Load-use costs exactly 1 bubble.
//  Not defined: fwd sels tied 0; ds_stall = any match in EX/MEM/WB; dependent instr waits until producer
//   leaves WB (up to 3 bubbles).
// STRUCTURE
//  mycpu_pkg: REG_AW, FWD_RF/FWD_ES/FWD_MS/FWD_WS encodings, stage_sb_t {valid, we, is_load, dest}.
//  Sub-module hazard_src_cmp (one source vs three scoreboard entries -> match vector, sel, load_hit),
//   instantiated twice (rj, rkd); rest is flat.
// TESTING
//  1 add r3,r1,r2 ; add r4,r3,r3 -> with _EN: fwd_rj_sel=fwd_rkd_sel=1, no stall; without: 3 bubbles.
//  2 ld.w r5 ; add r6,r5,r0 -> with _EN: ds_stall=1 one cycle, then fwd_rj_sel=2.
//  3 add r0,r1,r2 ; add r7,r0,r0 -> no stall, sels 0 (r0 ignored).
//  4 beq taken in ID, IF valid -> fs_flush=1 one cycle, next ds_valid=0; stalled beq -> fs_flush=0 until fire.
//  5 ms_mem_ready=0 for 4 cycles with all stages full -> ds_allowin=0, no fires, valids held.
//  6 resetn low mid-stream (async) -> all valid 0 immediately, ds_allowin=1 after release.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types for the pipeline hazard controller: forwarding encodings and scoreboard entries.
package mycpu_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_ES = 2'd1;
  localparam logic [1:0] FWD_MS = 2'd2;
  localparam logic [1:0] FWD_WS = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              is_load;
    logic [REG_AW-1:0] dest;
  } stage_sb_t;

  function automatic logic sb_hit(input stage_sb_t sb, input logic [REG_AW-1:0] src);
    return sb.valid & sb.we & (sb.dest == src);
  endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// One ID source register against the EX/MEM/WB scoreboard: forward select and stall request.
// Behaviour depends on PIPE_FWD_BYPASS_EN (bypass network present) vs. default (interlock only).
module hazard_src_cmp
  import mycpu_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  stage_sb_t         es_sb,
  input  stage_sb_t         ms_sb,
  input  stage_sb_t         ws_sb,
  input  logic              ms_ready,
  output logic [1:0]        sel,
  output logic              stall_req
);

  logic       src_live;
  logic [2:0] match;  // [0]=EX, [1]=MEM, [2]=WB

  assign src_live = use_src & (src != '0);
  assign match    = {3{src_live}} & {sb_hit(ws_sb, src), sb_hit(ms_sb, src), sb_hit(es_sb, src)};

`ifdef PIPE_FWD_BYPASS_EN
  logic unused_bits;
  assign unused_bits = &{1'b0, ws_sb.is_load};

  // Youngest producer wins; a WB hit still forwards since the regfile write lands this edge.
  always_comb begin
    sel = FWD_RF;
    if (match[0])      sel = FWD_ES;
    else if (match[1]) sel = FWD_MS;
    else if (match[2]) sel = FWD_WS;
  end

  assign stall_req = match[0] ? es_sb.is_load : (match[1] & ms_sb.is_load & ~ms_ready);
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, es_sb.is_load, ms_sb.is_load, ws_sb.is_load, ms_ready};

  assign sel       = FWD_RF;
  assign stall_req = |match;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: stage valids, allowin/ready_go handshakes, RAW interlock, forward selects.
// Define PIPE_FWD_BYPASS_EN to enable forwarding (only load-use stalls); otherwise full interlock.
module pipe_hazard_ctrl
  import mycpu_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              fs_to_ds_valid,
  input  logic [REG_AW-1:0] ds_rj,
  input  logic [REG_AW-1:0] ds_rkd,
  input  logic              ds_use_rj,
  input  logic              ds_use_rkd,
  input  logic [REG_AW-1:0] ds_dest,
  input  logic              ds_gr_we,
  input  logic              ds_is_load,
  input  logic              ds_br_taken,
  input  logic              ms_mem_ready,
  output logic              ds_allowin,
  output logic              ds_valid,
  output logic              es_valid,
  output logic              ms_valid,
  output logic              ws_valid,
  output logic              ds_to_es_fire,
  output logic              es_to_ms_fire,
  output logic              ms_to_ws_fire,
  output logic              fs_flush,
  output logic [1:0]        fwd_rj_sel,
  output logic [1:0]        fwd_rkd_sel,
  output logic              ds_stall
);

  logic      ds_valid_q, ds_valid_d;
  stage_sb_t es_q, es_d, ms_q, ms_d, ws_q, ws_d;
  logic      es_allowin, ms_allowin;
  logic      rj_stall, rkd_stall;

  hazard_src_cmp u_cmp_rj (
    .src      (ds_rj),
    .use_src  (ds_use_rj),
    .es_sb    (es_q),
    .ms_sb    (ms_q),
    .ws_sb    (ws_q),
    .ms_ready (ms_mem_ready),
    .sel      (fwd_rj_sel),
    .stall_req(rj_stall)
  );

  hazard_src_cmp u_cmp_rkd (
    .src      (ds_rkd),
    .use_src  (ds_use_rkd),
    .es_sb    (es_q),
    .ms_sb    (ms_q),
    .ws_sb    (ws_q),
    .ms_ready (ms_mem_ready),
    .sel      (fwd_rkd_sel),
    .stall_req(rkd_stall)
  );

  assign ds_stall = rj_stall | rkd_stall;

  // WB always accepts and EX always completes, so those ready_go/allowin terms fold to constants.
  assign ms_allowin = ~ms_q.valid | ms_mem_ready;
  assign es_allowin = ~es_q.valid | ms_allowin;
  assign ds_allowin = ~ds_valid_q | (~ds_stall & es_allowin);

  assign ds_to_es_fire = ds_valid_q & ~ds_stall & es_allowin;
  assign es_to_ms_fire = es_q.valid & ms_allowin;
  assign ms_to_ws_fire = ms_q.valid & ms_mem_ready;

  assign fs_flush = ds_br_taken & ds_to_es_fire;

  always_comb begin
    ds_valid_d = ds_valid_q;
    es_d       = es_q;
    ms_d       = ms_q;
    ws_d       = ws_q;
    if (ds_allowin) ds_valid_d = fs_to_ds_valid & ~fs_flush;
    if (es_allowin) begin
      es_d.valid = ds_to_es_fire;
      if (ds_to_es_fire) begin
        es_d.we      = ds_gr_we;
        es_d.is_load = ds_is_load;
        es_d.dest    = ds_dest;
      end
    end
    if (ms_allowin) begin
      ms_d.valid = es_to_ms_fire;
      if (es_to_ms_fire) begin
        ms_d.we      = es_q.we;
        ms_d.is_load = es_q.is_load;
        ms_d.dest    = es_q.dest;
      end
    end
    ws_d.valid = ms_to_ws_fire;
    if (ms_to_ws_fire) begin
      ws_d.we      = ms_q.we;
      ws_d.is_load = ms_q.is_load;
      ws_d.dest    = ms_q.dest;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_q <= 1'b0;
      es_q       <= '0;
      ms_q       <= '0;
      ws_q       <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      es_q       <= es_d;
      ms_q       <= ms_d;
      ws_q       <= ws_d;
    end
  end

  assign ds_valid = ds_valid_q;
  assign es_valid = es_q.valid;
  assign ms_valid = ms_q.valid;
  assign ws_valid = ws_q.valid;

endmodule
